// File: rtl/regf_wb_ctrl_pkg.sv
// Shared widths and source encoding for the register-file write-back controller.
package regf_wb_ctrl_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int REG_NUM   = 16;
    localparam int REG_AW    = 5;

    // Which producer owns the write port; also the encoding of the arbiter's last-grant flop.
    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regf_wb_ctrl_if.sv
// Issue / EXU / LSU / register-file signal bundle for regf_wb_ctrl.
interface regf_wb_ctrl_if
    import regf_wb_ctrl_pkg::*;
#(
    parameter int DW = CPU_WIDTH,
    parameter int RN = REG_NUM,
    parameter int AW = REG_AW
);
    logic          iss_valid;
    logic          iss_ready;
    logic          iss_wen;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] iss_rs1;
    logic [AW-1:0] iss_rs2;

    logic          exu_valid;
    logic          exu_ready;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;

    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;

    logic          rf_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [RN-1:0] busy;
    logic          err;

    // Controller side.
    modport slave (
        input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, exu_ready, lsu_ready,
        output rf_en, rf_waddr, rf_wdata, busy, err
    );

    // Issue stage / producers / register file side.
    modport master (
        output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, exu_ready, lsu_ready,
        input  rf_en, rf_waddr, rf_wdata, busy, err
    );
endinterface

// File: rtl/regf_wb_ctrl_wb_rr_arb.sv
// Two-requester round-robin arbiter (EXU vs LSU) with a one-hot grant.
module wb_rr_arb
    import regf_wb_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic exu_req,
    input  logic lsu_req,
    output logic exu_gnt,
    output logic lsu_gnt
);
    wb_src_e last;

    // Lone requester always wins; on a tie the side not granted last wins.
    always_comb begin
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (exu_req && lsu_req) begin
            exu_gnt = (last == SRC_LSU);
            lsu_gnt = (last == SRC_EXU);
        end else begin
            exu_gnt = exu_req;
            lsu_gnt = lsu_req;
        end
    end

    // Remember the most recent winner; reset to LSU so EXU takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         last <= SRC_LSU;
        else if (exu_gnt) last <= SRC_EXU;
        else if (lsu_gnt) last <= SRC_LSU;
    end
endmodule

// File: rtl/regf_wb_ctrl.sv
// Write-back controller: arbitrates EXU/LSU onto the regf write port and
// keeps a per-register busy scoreboard for issue hazard detection.
module regf_wb_ctrl
    import regf_wb_ctrl_pkg::*;
#(
    parameter int DW = CPU_WIDTH,
    parameter int RN = REG_NUM,
    parameter int AW = REG_AW
)(
    input  logic            clk,
    input  logic            rst,
    regf_wb_ctrl_if.slave   bus
);
    logic [RN-1:0] busy_q;
    logic [RN-1:0] set_mask;
    logic [RN-1:0] clr_mask;
    logic          hazard;
    logic          iss_fire;
    logic          exu_gnt;
    logic          lsu_gnt;
    logic          wb_fire;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          rf_en_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic          err_q;

    // One-hot of a register index; x0 and indices >= RN decode to nothing,
    // which makes them never busy and never settable.
    function automatic logic [RN-1:0] dec(input logic [AW-1:0] idx);
        logic [RN-1:0] m;
        m = '0;
        for (int i = 1; i < RN; i++)
            if (idx == AW'(i)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic is_busy(input logic [RN-1:0] v, input logic [AW-1:0] idx);
        return |(v & dec(idx));
    endfunction

    wb_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .exu_req (bus.exu_valid),
        .lsu_req (bus.lsu_valid),
        .exu_gnt (exu_gnt),
        .lsu_gnt (lsu_gnt)
    );

    // Hazard check, issue fire, and the selected write-back payload.
    always_comb begin
        hazard   = is_busy(busy_q, bus.iss_rs1) | is_busy(busy_q, bus.iss_rs2) |
                   (bus.iss_wen & is_busy(busy_q, bus.iss_rd));
        iss_fire = bus.iss_valid & ~hazard & bus.iss_wen;
        set_mask = iss_fire ? dec(bus.iss_rd) : '0;
        clr_mask = rf_en_q ? dec(rf_waddr_q) : '0;
        wb_fire  = exu_gnt | lsu_gnt;
        wb_rd    = exu_gnt ? bus.exu_rd   : bus.lsu_rd;
        wb_data  = exu_gnt ? bus.exu_data : bus.lsu_data;
    end

    // Scoreboard: clear lands on the regf write edge; set/clear of one bit
    // on the same edge cannot happen because the hazard blocks that issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end

    // Output register feeding regf; a write to x0 is accepted but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_en_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_en_q <= wb_fire && (wb_rd != '0);
            if (wb_fire) begin
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end
        end
    end

    // Sticky error: a producer wrote back a register nobody was waiting on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (wb_fire && (wb_rd != '0) && !is_busy(busy_q, wb_rd))
            err_q <= 1'b1;
    end

    assign bus.iss_ready = ~hazard;
    assign bus.exu_ready = exu_gnt;
    assign bus.lsu_ready = lsu_gnt;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Bench for regf_wb_ctrl: directed scenarios plus random traffic against a
// register-level reference model.
module tb_regf_wb_ctrl;
    localparam int DW = 32;
    localparam int RN = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regf_wb_ctrl_if #(.DW(DW), .RN(RN), .AW(AW)) bus ();

    regf_wb_ctrl #(.DW(DW), .RN(RN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit          m_busy [RN];
    bit          m_en;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_err;
    bit          m_exu_turn;   // EXU wins the next tie

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mbz(input int i);
        return (i > 0 && i < RN) ? m_busy[i] : 1'b0;
    endfunction

    function automatic logic [RN-1:0] mvec();
        logic [RN-1:0] v;
        for (int i = 0; i < RN; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
        m_en = 0; m_addr = 0; m_data = '0; m_err = 0; m_exu_turn = 1;
    endtask

    task automatic idle();
        bus.iss_valid = 0; bus.iss_wen = 0; bus.iss_rd = '0;
        bus.iss_rs1 = '0; bus.iss_rs2 = '0;
        bus.exu_valid = 0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    endtask

    task automatic set_iss(input bit v, input bit w, input int rd, input int rs1, input int rs2);
        bus.iss_valid = v; bus.iss_wen = w;
        bus.iss_rd = AW'(rd); bus.iss_rs1 = AW'(rs1); bus.iss_rs2 = AW'(rs2);
    endtask

    // One clock: check everything at the falling edge, then advance the model
    // across the rising edge. Inputs must already be set.
    task automatic cycle();
        bit hz, ge, gl;
        int r;
        @(negedge clk);
        hz = mbz(int'(bus.iss_rs1)) || mbz(int'(bus.iss_rs2)) ||
             (bus.iss_wen && mbz(int'(bus.iss_rd)));
        if (bus.exu_valid && bus.lsu_valid) begin
            ge = m_exu_turn; gl = !m_exu_turn;
        end else begin
            ge = bus.exu_valid; gl = bus.lsu_valid;
        end
        chk("iss_ready", 64'(bus.iss_ready), 64'(!hz));
        chk("exu_ready", 64'(bus.exu_ready), 64'(ge));
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(gl));
        chk("rf_en",     64'(bus.rf_en),     64'(m_en));
        if (m_en) begin
            chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_addr));
            chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_data));
        end
        chk("busy", 64'(bus.busy), 64'(mvec()));
        chk("err",  64'(bus.err),  64'(m_err));
        @(posedge clk);
        if (ge || gl) begin
            r = ge ? int'(bus.exu_rd) : int'(bus.lsu_rd);
            if (r != 0 && !mbz(r)) m_err = 1;
        end
        if (m_en && m_addr < RN) m_busy[m_addr] = 0;
        if (bus.iss_valid && !hz && bus.iss_wen && bus.iss_rd != 0 && int'(bus.iss_rd) < RN)
            m_busy[int'(bus.iss_rd)] = 1;
        if (ge || gl) begin
            m_addr = ge ? int'(bus.exu_rd) : int'(bus.lsu_rd);
            m_data = ge ? bus.exu_data : bus.lsu_data;
            m_en = (m_addr != 0);
            m_exu_turn = gl;
        end else begin
            m_en = 0;
        end
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic async_reset();
        idle();
        #2 rst = 0;
        #1;
        chk("rst_rf_en",    64'(bus.rf_en),    64'd0);
        chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_err",      64'(bus.err),      64'd0);
        model_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", 64'(bus.busy), 64'd0);
        chk("init_rf_en", 64'(bus.rf_en), 64'd0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // RAW: rd=5 issued, then a reader of x5 stalls until write-back.
        set_iss(1, 1, 5, 0, 0); cycle();
        set_iss(1, 0, 0, 5, 0); #1;
        chk("raw_stall", 64'(bus.iss_ready), 64'd0);
        chk("raw_busy5", 64'(bus.busy[5]), 64'd1);
        cycle(); cycle();
        bus.exu_valid = 1; bus.exu_rd = 5; bus.exu_data = 32'hDEADBEEF;
        cycle();
        bus.exu_valid = 0; #1;
        chk("raw_n1_en",    64'(bus.rf_en),    64'd1);
        chk("raw_n1_addr",  64'(bus.rf_waddr), 64'd5);
        chk("raw_n1_data",  64'(bus.rf_wdata), 64'hDEADBEEF);
        chk("raw_n1_stall", 64'(bus.iss_ready), 64'd0);
        cycle(); #1;
        chk("raw_n2_ready", 64'(bus.iss_ready), 64'd1);
        chk("raw_n2_busy5", 64'(bus.busy[5]), 64'd0);
        cycle();

        // x0: never busy, never written, never an error.
        set_iss(1, 1, 0, 0, 0); cycle();
        set_iss(0, 0, 0, 0, 0);
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h1234; cycle();
        bus.lsu_valid = 0; #1;
        chk("x0_busy",  64'(bus.busy),  64'd0);
        chk("x0_rf_en", 64'(bus.rf_en), 64'd0);
        chk("x0_err",   64'(bus.err),   64'd0);
        chk("x0_ready", 64'(bus.iss_ready), 64'd1);
        cycle();

        // WAW: second rd=9 waits for the first write-back to retire.
        set_iss(1, 1, 9, 0, 0); cycle(); #1;
        chk("waw_stall", 64'(bus.iss_ready), 64'd0);
        cycle();
        bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_data = 32'h99; cycle();
        bus.lsu_valid = 0; #1;
        chk("waw_n1_stall", 64'(bus.iss_ready), 64'd0);
        cycle(); #1;
        chk("waw_n2_ready", 64'(bus.iss_ready), 64'd1);
        cycle();
        set_iss(0, 0, 0, 0, 0);
        bus.exu_valid = 1; bus.exu_rd = 9; bus.exu_data = 32'h98; cycle();
        bus.exu_valid = 0; cycle(); cycle();

        // Reset with a write in flight, then the first tie must go to EXU.
        set_iss(1, 1, 2, 0, 0); cycle();
        set_iss(0, 0, 0, 0, 0);
        bus.exu_valid = 1; bus.exu_rd = 2; bus.exu_data = 32'h22; cycle();
        chk("pre_rst_en", 64'(bus.rf_en), 64'd1);
        async_reset();
        set_iss(1, 1, 3, 0, 0); cycle();
        set_iss(1, 1, 4, 0, 0); cycle();
        set_iss(0, 0, 0, 0, 0);
        bus.exu_valid = 1; bus.exu_rd = 3; bus.exu_data = 32'h33;
        bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h44;
        #1;
        chk("tie1_exu_gnt", 64'(bus.exu_ready), 64'd1);
        cycle(); #1;
        chk("tie1_addr", 64'(bus.rf_waddr), 64'd3);
        chk("tie2_lsu_gnt", 64'(bus.lsu_ready), 64'd1);
        cycle();
        bus.exu_valid = 0; bus.lsu_valid = 0; #1;
        chk("tie2_addr", 64'(bus.rf_waddr), 64'd4);
        chk("tie2_en",   64'(bus.rf_en),    64'd1);
        chk("tie_err",   64'(bus.err),      64'd0);
        cycle(); cycle();

        // Error: write-back to a register nobody is waiting on.
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h77; cycle();
        bus.lsu_valid = 0; #1;
        chk("err_set", 64'(bus.err), 64'd1);
        repeat (3) cycle();
        chk("err_hold", 64'(bus.err), 64'd1);

        // Random traffic, with an asynchronous reset every 100 cycles.
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 50) async_reset();
            set_iss($urandom_range(0, 1), ($urandom_range(0, 9) < 7),
                    $urandom_range(0, 19), $urandom_range(0, 19), $urandom_range(0, 19));
            bus.exu_valid = ($urandom_range(0, 9) < 4);
            bus.exu_rd    = AW'($urandom_range(0, 19));
            bus.exu_data  = $urandom;
            bus.lsu_valid = ($urandom_range(0, 9) < 4);
            bus.lsu_rd    = AW'($urandom_range(0, 19));
            bus.lsu_data  = $urandom;
            cycle();
        end
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
